// File: rtl/seq_alu_pkg.sv
// Shared types and constants for the sequential ALU: op codes, FSM states,
// and helpers that do not depend on WIDTH.
package seq_alu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SLTU  = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_NOR   = 4'b0101,
    OP_SUB   = 4'b0110,
    OP_SLT   = 4'b0111,
    OP_MULT  = 4'b1000,
    OP_MULTU = 4'b1001,
    OP_DIV   = 4'b1010,
    OP_DIVU  = 4'b1011
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Codes 10xx form the multi-cycle group; bit 1 picks divide, bit 0 picks unsigned.
  function automatic logic is_muldiv_op(input logic [OP_W-1:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative engine: shift-add multiplier and restoring divider, one bit per cycle.
// Works on magnitudes and fixes signs on the final iteration.
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             div_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q;
  logic             div_q, neg_lo_q, neg_hi_q, dbz_q;
  logic [WIDTH-1:0] a_q;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_trial;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt, prod;
  logic [WIDTH-1:0] quo, rem;

  always_comb begin
    a_neg = signed_i & a_i[WIDTH-1];
    b_neg = signed_i & b_i[WIDTH-1];
    a_mag = a_neg ? -a_i : a_i;
    b_mag = b_neg ? -b_i : b_i;

    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};

    // Trial subtract of the shifted partial remainder; keep it only if non-negative.
    div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    div_nxt   = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                 : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    acc_d  = div_q ? div_nxt : mul_nxt;
    done_o = busy_q && (cnt_q == CW'(WIDTH - 1));

    prod = neg_lo_q ? -acc_d : acc_d;
    quo  = neg_lo_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
    rem  = neg_hi_q ? -acc_d[2*WIDTH-1:WIDTH] : acc_d[2*WIDTH-1:WIDTH];

    if (!div_q) begin
      lo_o = prod[WIDTH-1:0];
      hi_o = prod[2*WIDTH-1:WIDTH];
    end else if (dbz_q) begin
      lo_o = '1;
      hi_o = a_q;
    end else begin
      lo_o = quo;
      hi_o = rem;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dbz_q    <= 1'b0;
      a_q      <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= {{WIDTH{1'b0}}, (div_i ? a_mag : b_mag)};
      opnd_q   <= div_i ? b_mag : a_mag;
      div_q    <= div_i;
      neg_lo_q <= a_neg ^ b_neg;
      neg_hi_q <= a_neg;
      dbz_q    <= div_i && (b_i == '0);
      a_q      <= a_i;
    end else if (busy_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshake; multi-cycle MULT/DIV group is
// present only when SEQ_ALU_MULDIV_EN is defined.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output state_e           state_o
);

  // Handshake: an op transfers on a rising edge with in_valid & in_ready; a
  // result transfers with out_valid & out_ready. Only one op is in flight.
  state_e           state_q;
  logic [WIDTH-1:0] result_q, hi_q;
  logic             zero_q;
  logic [WIDTH-1:0] alu_res;
  logic             accept;

  assign accept    = in_valid && (state_q == ST_IDLE);
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign hi        = hi_q;
  assign zero      = zero_q;
  assign state_o   = state_q;

  always_comb begin
    alu_res = '0;
    case (op)
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_ADD:  alu_res = src_a + src_b;
      OP_SUB:  alu_res = src_a - src_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_NOR:  alu_res = ~(src_a | src_b);
      default: alu_res = '0;
    endcase
  end

`ifdef SEQ_ALU_MULDIV_EN
  logic             eng_start, eng_done;
  logic [WIDTH-1:0] eng_lo, eng_hi;

  assign eng_start = accept && is_muldiv_op(op);

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start_i  (eng_start),
    .div_i    (op[1]),
    .signed_i (~op[0]),
    .a_i      (src_a),
    .b_i      (src_b),
    .done_o   (eng_done),
    .lo_o     (eng_lo),
    .hi_o     (eng_hi)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
`ifdef SEQ_ALU_MULDIV_EN
            if (is_muldiv_op(op)) begin
              state_q <= op[1] ? ST_DIV : ST_MUL;
            end else begin
              state_q  <= ST_DONE;
              result_q <= alu_res;
              hi_q     <= '0;
              zero_q   <= (alu_res == '0);
            end
`else
            state_q  <= ST_DONE;
            result_q <= alu_res;
            hi_q     <= '0;
            zero_q   <= (alu_res == '0);
`endif
          end
        end
`ifdef SEQ_ALU_MULDIV_EN
        ST_MUL, ST_DIV: begin
          if (eng_done) begin
            state_q  <= ST_DONE;
            result_q <= eng_lo;
            hi_q     <= eng_hi;
            zero_q   <= (eng_lo == '0);
          end
        end
`endif
        ST_DONE: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed cases plus randomized ops
// compared against an arithmetic reference model.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [3:0]   op;
  logic [W-1:0] src_a, src_b;
  logic         out_valid, out_ready;
  logic [W-1:0] result, hi;
  logic         zero;
  state_e       state_o;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_res, last_hi;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .hi        (hi),
    .zero      (zero),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic muldiv_enabled();
`ifdef SEQ_ALU_MULDIV_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: plain arithmetic on the operation definitions.
  task automatic model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic [W-1:0] h, output int lat);
    logic [63:0] p;
    longint sp;
    r = '0; h = '0; lat = 1;
    case (o)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'b0011: r = (a < b) ? 1 : 0;
      4'b0100: r = a ^ b;
      4'b0101: r = ~(a | b);
      4'b1000, 4'b1001, 4'b1010, 4'b1011: begin
        if (muldiv_enabled()) begin
          lat = W + 1;
          if (o == 4'b1000) begin
            sp = longint'($signed(a)) * longint'($signed(b));
            p = sp;
            r = p[31:0]; h = p[63:32];
          end else if (o == 4'b1001) begin
            p = {32'd0, a} * {32'd0, b};
            r = p[31:0]; h = p[63:32];
          end else if (b == 0) begin
            r = '1; h = a;
          end else if (o == 4'b1010) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
              r = a; h = 0;
            end else begin
              r = $signed(a) / $signed(b);
              h = $signed(a) % $signed(b);
            end
          end else begin
            r = a / b; h = a % b;
          end
        end
      end
      default: begin r = '0; h = '0; end
    endcase
  endtask

  task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold);
    logic [W-1:0] r, h, er, eh;
    int exp_lat, lat;
    model(o, a, b, r, h, exp_lat);
    exp_q.push_back(r);
    exp_q.push_back(h);
    @(negedge clk);
    check($sformatf("in_ready_idle op%0h", o), in_ready, 1);
    in_valid = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    er = exp_q.pop_front();
    eh = exp_q.pop_front();
    check($sformatf("latency op%0h", o), lat, exp_lat);
    check($sformatf("result op%0h a=%0h b=%0h", o, a, b), result, er);
    check($sformatf("hi op%0h a=%0h b=%0h", o, a, b), hi, eh);
    check($sformatf("zero op%0h", o), zero, (er == 0));
    last_res = result;
    last_hi  = hi;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_result", result, er);
      check("hold_hi", hi, eh);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drain_out_valid", out_valid, 0);
    check("drain_in_ready", in_ready, 1);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 4))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return W'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic seen_valid;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_hi", hi, 0);
    check("rst_zero", zero, 1);
    @(negedge clk); rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);

    run_op(4'b0010, 5, 7, 0);
    check("add_5_7", last_res, 12);
    run_op(4'b0110, 3, 3, 0);
    check("sub_3_3", last_res, 0);
    run_op(4'b0111, 32'hFFFF_FFFF, 1, 0);
    check("slt_m1_1", last_res, 1);
    run_op(4'b0011, 32'hFFFF_FFFF, 1, 0);
    check("sltu_max_1", last_res, 0);
    run_op(4'b1111, 32'h1234, 32'h5678, 0);
    check("illegal_res", last_res, 0);
    check("illegal_hi", last_hi, 0);
    run_op(4'b0101, 32'h0F0F_0000, 32'h0000_00FF, 5);

`ifdef SEQ_ALU_MULDIV_EN
    run_op(4'b1000, 32'hFFFF_FFFE, 3, 0);
    check("mult_res", last_res, 32'hFFFF_FFFA);
    check("mult_hi", last_hi, 32'hFFFF_FFFF);
    run_op(4'b1001, 32'hFFFF_FFFF, 2, 0);
    check("multu_res", last_res, 32'hFFFF_FFFE);
    check("multu_hi", last_hi, 1);
    run_op(4'b1010, 32'hFFFF_FFF9, 2, 0);
    check("div_res", last_res, 32'hFFFF_FFFD);
    check("div_hi", last_hi, 32'hFFFF_FFFF);
    run_op(4'b1011, 7, 0, 0);
    check("divu0_res", last_res, 32'hFFFF_FFFF);
    check("divu0_hi", last_hi, 7);
    run_op(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF, 3);
    check("div_ovf_res", last_res, 32'h8000_0000);
    check("div_ovf_hi", last_hi, 0);
`else
    run_op(4'b1000, 32'hFFFF_FFFE, 3, 0);
    check("mult_disabled", last_res, 0);
`endif

    for (int n = 0; n < 60; n++) begin
      run_op(4'($urandom_range(0, 15)), pick_operand(), pick_operand(), $urandom_range(0, 2));
    end

    // Abandon an in-flight operation with reset.
    @(negedge clk);
`ifdef SEQ_ALU_MULDIV_EN
    in_valid = 1'b1; op = 4'b1011; src_a = 100; src_b = 3;
`else
    in_valid = 1'b1; op = 4'b0010; src_a = 1; src_b = 1;
`endif
    @(negedge clk); in_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    check("midop_in_ready", in_ready, 1);
    check("midop_result", result, 0);
    seen_valid = 1'b0;
    out_ready = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    check("midop_no_valid", seen_valid, 0);
    run_op(4'b0100, 32'hAAAA_5555, 32'hFFFF_0000, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
